// File: rtl/store_narrow_if.sv
// Store request channel and 16-bit memory write channel.
// The master side is the core/memory environment; the slave side is the narrowing unit.
interface store_narrow_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;

    modport master (
        output req_valid, req_addr, req_wdata, req_size, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_size, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/store_narrow.sv
// Store-path narrowing: splits a 32-bit byte/half/word store into one or two
// 16-bit write beats with byte strobes. Misaligned or illegal-size stores are
// rejected with a one-cycle err pulse and never reach memory.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | ready for a request; err/done pulses are visible here
// BEAT0 | first (or only) beat presented, waiting for mem_ready
// BEAT1 | upper halfword of a word store presented, waiting for mem_ready
module store_narrow (
    input  logic          clk,
    input  logic          rst_n,
    store_narrow_if.slave bus,
    output logic          done,
    output logic          err,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]  mem_be_q, mem_be_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        word_q, word_d;
    logic [15:0] hi_q, hi_d;
    logic        reject;

    // Size/alignment legality of the request currently on the bus.
    always_comb begin
        reject = 1'b0;
        unique case (bus.req_size)
            2'b00:   reject = 1'b0;
            2'b01:   reject = bus.req_addr[0];
            2'b10:   reject = (bus.req_addr[1:0] != 2'b00);
            default: reject = 1'b1;
        endcase
    end

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        word_d      = word_q;
        hi_d        = hi_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (reject) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = BEAT0;
                        mem_valid_d = 1'b1;
                        word_d      = (bus.req_size == 2'b10);
                        // Upper halfword is kept so later req_* changes cannot affect BEAT1.
                        hi_d        = bus.req_wdata[31:16];
                        if (bus.req_size == 2'b00) begin
                            // Byte lane is replicated; the strobe selects the live lane.
                            mem_addr_d  = {bus.req_addr[31:1], 1'b0};
                            mem_wdata_d = {bus.req_wdata[7:0], bus.req_wdata[7:0]};
                            mem_be_d    = bus.req_addr[0] ? 2'b10 : 2'b01;
                        end else begin
                            mem_addr_d  = bus.req_addr;
                            mem_wdata_d = bus.req_wdata[15:0];
                            mem_be_d    = 2'b11;
                        end
                    end
                end
            end
            BEAT0: begin
                if (bus.mem_ready) begin
                    if (word_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = mem_addr_q + 32'd2;
                        mem_wdata_d = hi_q;
                        mem_be_d    = 2'b11;
                    end else begin
                        state_d     = IDLE;
                        mem_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            BEAT1: begin
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset abandons any pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 16'd0;
            mem_be_q    <= 2'b00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            word_q      <= 1'b0;
            hi_q        <= 16'd0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            word_q      <= word_d;
            hi_q        <= hi_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign done          = done_q;
    assign err           = err_q;
    assign busy          = busy_q;

endmodule
